// File: rtl/pea_ctx_sequencer_if.sv
// pea_ctx_sequencer_if
//   Command / status bundle between the register file (master) and the
//   PEA context sequencer (slave).
//   master drives : start_i, abort_i, n_ctx_i, n_iter_i, stall_i
//   slave drives  : ctx_sel_o, pe_en_o, last_o, iter_cnt_o, busy_o, done_o
interface pea_ctx_sequencer_if #(
  parameter int N_CFG_REGS_PE = 4,
  parameter int ITER_W        = 16
);
  localparam int LOG_CTX = $clog2(N_CFG_REGS_PE);

  logic               start_i;
  logic               abort_i;
  logic [LOG_CTX:0]   n_ctx_i;
  logic [ITER_W-1:0]  n_iter_i;
  logic               stall_i;
  logic [LOG_CTX-1:0] ctx_sel_o;
  logic               pe_en_o;
  logic               last_o;
  logic [ITER_W-1:0]  iter_cnt_o;
  logic               busy_o;
  logic               done_o;

  modport master (
    output start_i, abort_i, n_ctx_i, n_iter_i, stall_i,
    input  ctx_sel_o, pe_en_o, last_o, iter_cnt_o, busy_o, done_o
  );

  modport slave (
    input  start_i, abort_i, n_ctx_i, n_iter_i, stall_i,
    output ctx_sel_o, pe_en_o, last_o, iter_cnt_o, busy_o, done_o
  );
endinterface

// File: rtl/pea_ctx_sequencer.sv
// pea_ctx_sequencer
//   Steps all PEs in lock-step through n_ctx configuration contexts for
//   n_iter iterations, freezing on stall, draining PEA_LAT cycles after the
//   final issue and pulsing done.
//   clk_i  : clock
//   rst_i  : synchronous reset, active-high
//   bus    : slave side of pea_ctx_sequencer_if (start/abort/counts/stall in,
//            ctx_sel/pe_en/last/iter_cnt/busy/done out)
module pea_ctx_sequencer #(
  parameter int N_CFG_REGS_PE = 4,
  parameter int ITER_W        = 16,
  parameter int PEA_LAT       = 2
) (
  input logic                 clk_i,
  input logic                 rst_i,
  pea_ctx_sequencer_if.slave  bus
);
  localparam int LOG_CTX  = $clog2(N_CFG_REGS_PE);
  localparam int CW       = LOG_CTX + 1;
  localparam int DW       = (PEA_LAT > 1) ? $clog2(PEA_LAT) : 1;
  localparam int DRN_LAST = (PEA_LAT > 0) ? PEA_LAT - 1 : 0;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             r_state;
  logic [LOG_CTX-1:0] r_ctx;
  logic [ITER_W-1:0]  r_iter;
  logic [CW-1:0]      r_n_ctx;
  logic [ITER_W-1:0]  r_n_iter;
  logic [DW-1:0]      r_drain;
  logic               r_busy;
  logic               r_done;

  logic               w_pe_en;
  logic               w_ctx_end;
  logic               w_iter_end;
  logic               w_last;
  logic [CW-1:0]      w_n_ctx_clamp;

  // Abort kills the issue in the same cycle it is seen.
  assign w_pe_en    = (r_state == S_RUN) && !bus.stall_i && !bus.abort_i;
  assign w_ctx_end  = ({1'b0, r_ctx} == (r_n_ctx - CW'(1)));
  assign w_iter_end = (r_iter == (r_n_iter - ITER_W'(1)));
  assign w_last     = w_pe_en && w_ctx_end && w_iter_end;

  always_comb begin
    w_n_ctx_clamp = bus.n_ctx_i;
    if (bus.n_ctx_i == '0)
      w_n_ctx_clamp = CW'(1);
    else if (bus.n_ctx_i > CW'(N_CFG_REGS_PE))
      w_n_ctx_clamp = CW'(N_CFG_REGS_PE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_ctx    <= '0;
      r_iter   <= '0;
      r_n_ctx  <= CW'(1);
      r_n_iter <= '0;
      r_drain  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else if (bus.abort_i && r_state != S_IDLE) begin
      r_state <= S_IDLE;
      r_ctx   <= '0;
      r_iter  <= '0;
      r_drain <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start_i) begin
            r_n_ctx  <= w_n_ctx_clamp;
            r_n_iter <= bus.n_iter_i;
            r_ctx    <= '0;
            r_iter   <= '0;
            r_drain  <= '0;
            if (bus.n_iter_i == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_pe_en) begin
            if (w_ctx_end) begin
              r_ctx  <= '0;
              r_iter <= r_iter + ITER_W'(1);
            end else begin
              r_ctx  <= r_ctx + LOG_CTX'(1);
            end
            if (w_last) begin
              if (PEA_LAT == 0) begin
                // Straight to DONE: counters read 0 there.
                r_state <= S_DONE;
                r_ctx   <= '0;
                r_iter  <= '0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                // Counters keep the post-wrap values through DRAIN.
                r_state <= S_DRAIN;
                r_drain <= '0;
              end
            end
          end
        end
        S_DRAIN: begin
          // Drain is time-based only; stall has no effect here.
          if (r_drain == DW'(DRN_LAST)) begin
            r_state <= S_DONE;
            r_ctx   <= '0;
            r_iter  <= '0;
            r_drain <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_drain <= r_drain + DW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ctx_sel_o  = r_ctx;
  assign bus.iter_cnt_o = r_iter;
  assign bus.pe_en_o    = w_pe_en;
  assign bus.last_o     = w_last;
  assign bus.busy_o     = r_busy;
  // An abort landing in the DONE cycle must swallow the completion pulse,
  // so the registered flag is qualified with abort here.
  assign bus.done_o     = r_done && !bus.abort_i;
endmodule
